// File: rtl/jtkicker_romarb_if.sv
// Bus bundle for the ROM arbiter: game-side ROM ports plus the SDRAM read channel.
// master is the arbiter side, slave is the game/SDRAM environment side.
interface jtkicker_romarb_if #(
   parameter int N  = 4,
   parameter int AW = 22
);
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_cs;
   logic [N*8-1:0]  req_data;
   logic [N-1:0]    req_ok;
   logic [21:0]     sdram_addr;
   logic            sdram_rd;
   logic            sdram_ack;
   logic            sdram_dst;
   logic [15:0]     sdram_dout;
   logic            busy;

   modport master (
      input  req_addr, req_cs, sdram_ack, sdram_dst, sdram_dout,
      output req_data, req_ok, sdram_addr, sdram_rd, busy
   );

   modport slave (
      output req_addr, req_cs, sdram_ack, sdram_dst, sdram_dout,
      input  req_data, req_ok, sdram_addr, sdram_rd, busy
   );
endinterface

// File: rtl/jtkicker_romarb.sv
// Shares one SDRAM read port between N ROM requesters, each with a one-word cache.
// Misses are served one at a time, round-robin from the pointer.
//
// state  | meaning
// IDLE   | no transaction; arbitrate among misses
// REQ    | sdram_rd held until sdram_ack
// WAIT   | read accepted, waiting for sdram_dst
// FILL   | cache entry written; advance pointer past the grantee
module jtkicker_romarb #(
   parameter int                N       = 4,
   parameter int                AW      = 22,
   parameter logic [N*22-1:0]   OFFSETS = '0
)(
   input  logic              clk,
   input  logic              rst,
   jtkicker_romarb_if.master bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_FILL = 2'd3;

   logic [1:0]    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] gnt;
   logic [IW-1:0] gnt_nxt;
   logic          found;
   logic          fill;
   logic          rd;
   logic [21:0]   rd_addr;
   logic [N-1:0]  valid;
   logic [N-1:0]  hit;
   logic [N-1:0]  miss;
   logic [20:0]   tag       [N];
   logic [15:0]   word      [N];
   logic [21:0]   byte_addr [N];
   logic [N*8-1:0] data_mux;

   // Offset add wraps in 22 bits; bit 0 picks the byte, the rest is the word tag.
   always_comb begin
      data_mux = '0;
      for (int i = 0; i < N; i++) begin
         byte_addr[i] = OFFSETS[i*22 +: 22] + 22'(bus.req_addr[i*AW +: AW]);
         hit[i]       = bus.req_cs[i] & valid[i] & (tag[i] == byte_addr[i][21:1]);
         miss[i]      = bus.req_cs[i] & ~hit[i];
         data_mux[i*8 +: 8] = byte_addr[i][0] ? word[i][15:8] : word[i][7:0];
      end
   end

   always_comb begin
      found   = 1'b0;
      gnt_nxt = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && miss[(int'(ptr) + k) % N]) begin
            found   = 1'b1;
            gnt_nxt = IW'((int'(ptr) + k) % N);
         end
      end
   end

   // An ack with a same-cycle strobe skips WAIT.
   assign fill = ((state == S_REQ) && bus.sdram_ack && bus.sdram_dst) ||
                 ((state == S_WAIT) && bus.sdram_dst);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         ptr     <= '0;
         gnt     <= '0;
         rd      <= 1'b0;
         rd_addr <= '0;
         valid   <= '0;
         for (int i = 0; i < N; i++) begin
            tag[i]  <= '0;
            word[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  gnt     <= gnt_nxt;
                  rd_addr <= {1'b0, byte_addr[gnt_nxt][21:1]};
                  rd      <= 1'b1;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.sdram_ack) begin
                  rd    <= 1'b0;
                  state <= bus.sdram_dst ? S_FILL : S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.sdram_dst) state <= S_FILL;
            end
            S_FILL: begin
               ptr   <= (gnt == IW'(N-1)) ? '0 : gnt + IW'(1);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Tag comes from the latched address, so a requester that moved meanwhile stays a miss.
         if (fill) begin
            word[gnt]  <= bus.sdram_dout;
            tag[gnt]   <= rd_addr[20:0];
            valid[gnt] <= 1'b1;
         end
      end
   end

   assign bus.req_data   = data_mux;
   assign bus.req_ok     = hit;
   assign bus.sdram_addr = rd_addr;
   assign bus.sdram_rd   = rd;
   assign bus.busy       = (state != S_IDLE);
endmodule
